// File: rtl/adc_channel_averager.sv
// rtl/adc_channel_averager.sv - per-channel boxcar decimator for the ADC response stream
module adc_channel_averager #(
    parameter int NUM_CH   = 9,
    parameter int LOG2_AVG = 4,
    parameter int DATA_W   = 12
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              clear,
    input  logic              adc_valid,
    input  logic              adc_startofpacket,
    input  logic              adc_endofpacket,
    input  logic [4:0]        adc_channel,
    input  logic [DATA_W-1:0] adc_data,
    output logic              avg_valid,
    input  logic              avg_ready,
    output logic [4:0]        avg_channel,
    output logic [DATA_W-1:0] avg_data,
    output logic              overrun,
    output logic [7:0]        drop_count
);

    // Accumulator is wide enough for a full block of max-scale samples.
    localparam int ACC_W = DATA_W + LOG2_AVG;
    // A one-bit counter is kept for pass-through so the arrays stay legal.
    localparam int CNT_W = (LOG2_AVG == 0) ? 1 : LOG2_AVG;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);

    logic [ACC_W-1:0]  acc [NUM_CH];
    logic [CNT_W-1:0]  cnt [NUM_CH];

    logic              ch_ok;
    logic              accept;
    logic              reject;
    logic              block_done;
    logic [ACC_W-1:0]  sel_acc;
    logic [CNT_W-1:0]  sel_cnt;
    logic [ACC_W-1:0]  sum;
    logic [DATA_W-1:0] result;

    // Classify the incoming sample and pick out its channel's running state.
    always_comb begin
        ch_ok   = ({1'b0, adc_channel} < 6'(NUM_CH));
        accept  = adc_valid & adc_startofpacket & adc_endofpacket & ch_ok;
        reject  = adc_valid & ~accept;
        sel_acc = '0;
        sel_cnt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (adc_channel == 5'(c)) begin
                sel_acc = acc[c];
                sel_cnt = cnt[c];
            end
        end
        sum        = sel_acc + ACC_W'(adc_data);
        block_done = accept & (sel_cnt == CNT_LAST);
        result     = DATA_W'(sum >> LOG2_AVG);
    end

    // Per-channel accumulators: add until the block is full, then restart from zero.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c] <= '0;
                cnt[c] <= '0;
            end
        end else if (clear) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c] <= '0;
                cnt[c] <= '0;
            end
        end else if (accept) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (adc_channel == 5'(c)) begin
                    if (block_done) begin
                        acc[c] <= '0;
                        cnt[c] <= '0;
                    end else begin
                        acc[c] <= sum;
                        cnt[c] <= sel_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Single-entry output register; a result arriving while stalled is dropped and flagged.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            avg_valid   <= 1'b0;
            avg_channel <= '0;
            avg_data    <= '0;
            overrun     <= 1'b0;
        end else if (clear) begin
            avg_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (block_done) begin
            if (!avg_valid || avg_ready) begin
                avg_valid   <= 1'b1;
                avg_channel <= adc_channel;
                avg_data    <= result;
            end else begin
                overrun <= 1'b1;
            end
        end else if (avg_valid && avg_ready) begin
            avg_valid <= 1'b0;
        end
    end

    // Saturating count of malformed or out-of-range samples.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            drop_count <= '0;
        end else if (clear) begin
            drop_count <= '0;
        end else if (reject && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_adc_channel_averager.sv
// tb/tb_adc_channel_averager.sv - directed bench for adc_channel_averager
module tb_adc_channel_averager;

    logic        clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic        clear = 1'b0;
    logic        adc_valid = 1'b0;
    logic        adc_sop = 1'b0;
    logic        adc_eop = 1'b0;
    logic [4:0]  adc_channel = '0;
    logic [11:0] adc_data = '0;
    logic        avg_ready = 1'b1;

    logic        avg_valid, overrun;
    logic [4:0]  avg_channel;
    logic [11:0] avg_data;
    logic [7:0]  drop_count;

    logic        avg0_valid, overrun0;
    logic [4:0]  avg0_channel;
    logic [11:0] avg0_data;
    logic [7:0]  drop_count0;

    int total = 0;
    int bad   = 0;

    logic [16:0] rq[$];

    always #5 clk = ~clk;

    adc_channel_averager #(.NUM_CH(9), .LOG2_AVG(4), .DATA_W(12)) u_dut (
        .clk_clk(clk), .reset_reset(reset_reset), .clear(clear),
        .adc_valid(adc_valid), .adc_startofpacket(adc_sop), .adc_endofpacket(adc_eop),
        .adc_channel(adc_channel), .adc_data(adc_data),
        .avg_valid(avg_valid), .avg_ready(avg_ready), .avg_channel(avg_channel),
        .avg_data(avg_data), .overrun(overrun), .drop_count(drop_count)
    );

    adc_channel_averager #(.NUM_CH(9), .LOG2_AVG(0), .DATA_W(12)) u_dut0 (
        .clk_clk(clk), .reset_reset(reset_reset), .clear(clear),
        .adc_valid(adc_valid), .adc_startofpacket(adc_sop), .adc_endofpacket(adc_eop),
        .adc_channel(adc_channel), .adc_data(adc_data),
        .avg_valid(avg0_valid), .avg_ready(avg_ready), .avg_channel(avg0_channel),
        .avg_data(avg0_data), .overrun(overrun0), .drop_count(drop_count0)
    );

    // Record every result accepted downstream from the averaging instance.
    always @(negedge clk) begin
        if (!reset_reset && avg_valid && avg_ready)
            rq.push_back({avg_channel, avg_data});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic clr, input logic v, input logic sop, input logic eop,
                         input logic [4:0] ch, input logic [11:0] d);
        @(posedge clk);
        #1;
        clear       = clr;
        adc_valid   = v;
        adc_sop     = sop;
        adc_eop     = eop;
        adc_channel = ch;
        adc_data    = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 12'd0);
    endtask

    task automatic burst(input int n, input logic [4:0] ch, input logic [11:0] d);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b1, 1'b1, ch, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        #2;
        chk("rst_valid", 32'(avg_valid), 32'd0);
        chk("rst_ch", 32'(avg_channel), 32'd0);
        chk("rst_data", 32'(avg_data), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_reset = 1'b0;

        // 1: 16 samples ch3 -> one result one clock after the 16th
        idle(2);
        rq.delete();
        burst(16, 5'd3, 12'h100);
        @(negedge clk);
        chk("t1_not_early", 32'(avg_valid), 32'd0);
        idle(1);
        @(negedge clk);
        chk("t1_valid", 32'(avg_valid), 32'd1);
        chk("t1_ch", 32'(avg_channel), 32'd3);
        chk("t1_data", 32'(avg_data), 32'h100);
        idle(2);
        @(negedge clk);
        chk("t1_drop_valid", 32'(avg_valid), 32'd0);
        chk("t1_count", 32'(rq.size()), 32'd1);

        // 2: interleaved channels stay independent
        rq.delete();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 12'hFFF);
            drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 12'h001);
        end
        idle(3);
        @(negedge clk);
        chk("t2_count", 32'(rq.size()), 32'd2);
        chk("t2_ch1", 32'(rq[0]), 32'({5'd1, 12'hFFF}));
        chk("t2_ch2", 32'(rq[1]), 32'({5'd2, 12'h001}));

        // 3: stalled output keeps first result, second is lost and flagged
        rq.delete();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 12'd0);
        avg_ready = 1'b0;
        burst(16, 5'd0, 12'h010);
        burst(16, 5'd5, 12'h020);
        idle(2);
        @(negedge clk);
        chk("t3_ovr", 32'(overrun), 32'd1);
        chk("t3_held_valid", 32'(avg_valid), 32'd1);
        chk("t3_held_ch", 32'(avg_channel), 32'd0);
        chk("t3_held_data", 32'(avg_data), 32'h010);
        chk("t3_none_yet", 32'(rq.size()), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 12'd0);
        avg_ready = 1'b1;
        idle(3);
        @(negedge clk);
        chk("t3_count", 32'(rq.size()), 32'd1);
        chk("t3_ch0", 32'(rq[0]), 32'({5'd0, 12'h010}));
        chk("t3_valid_off", 32'(avg_valid), 32'd0);
        chk("t3_ovr_sticky", 32'(overrun), 32'd1);

        // 4: rejected samples are counted, saturate, and never accumulate
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 12'd0);
        rq.delete();
        for (int i = 0; i < 100; i++) drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd12, 12'hFFF);
        @(negedge clk);
        chk("t4_ovr_cleared", 32'(overrun), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 12'd0);
        @(negedge clk);
        chk("t4_drop100", 32'(drop_count), 32'd100);
        for (int i = 0; i < 100; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd6, 12'hFFF);
        for (int i = 0; i < 100; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd6, 12'hFFF);
        idle(1);
        @(negedge clk);
        chk("t4_drop_sat", 32'(drop_count), 32'd255);
        chk("t4_no_result", 32'(rq.size()), 32'd0);
        burst(16, 5'd6, 12'h003);
        idle(2);
        @(negedge clk);
        chk("t4_clean_count", 32'(rq.size()), 32'd1);
        chk("t4_clean_ch6", 32'(rq[0]), 32'({5'd6, 12'h003}));

        // 5: clear discards partial block and the coincident sample
        rq.delete();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 12'd0);
        avg_ready = 1'b0;
        burst(16, 5'd0, 12'h001);
        burst(16, 5'd1, 12'h001);
        burst(8, 5'd4, 12'h0F0);
        @(negedge clk);
        chk("t5_ovr_set", 32'(overrun), 32'd1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 12'h0F0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 12'd0);
        avg_ready = 1'b1;
        @(negedge clk);
        chk("t5_ovr_clr", 32'(overrun), 32'd0);
        chk("t5_drop_clr", 32'(drop_count), 32'd0);
        chk("t5_valid_clr", 32'(avg_valid), 32'd0);
        burst(15, 5'd4, 12'h00A);
        idle(2);
        @(negedge clk);
        chk("t5_not_early", 32'(rq.size()), 32'd0);
        burst(1, 5'd4, 12'h00A);
        idle(2);
        @(negedge clk);
        chk("t5_count", 32'(rq.size()), 32'd1);
        chk("t5_ch4", 32'(rq[0]), 32'({5'd4, 12'h00A}));

        // 6: pass-through instance, then asynchronous reset mid-stream
        idle(2);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 12'h5A5);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 12'h5A5);
        @(negedge clk);
        chk("t6_not_early", 32'(avg0_valid), 32'd0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 12'h5A5);
        @(negedge clk);
        chk("t6_valid", 32'(avg0_valid), 32'd1);
        chk("t6_ch", 32'(avg0_channel), 32'd7);
        chk("t6_data", 32'(avg0_data), 32'h5A5);
        chk("t6_drop_pre", 32'(drop_count0), 32'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 12'h5A5);
        #2 reset_reset = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(avg0_valid), 32'd0);
        chk("t6_rst_ch", 32'(avg0_channel), 32'd0);
        chk("t6_rst_data", 32'(avg0_data), 32'd0);
        chk("t6_rst_drop0", 32'(drop_count0), 32'd0);
        chk("t6_rst_drop", 32'(drop_count), 32'd0);
        chk("t6_rst_ovr", 32'(overrun0), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 12'd0);
        #1 reset_reset = 1'b0;
        rq.delete();
        burst(15, 5'd7, 12'h5A5);
        idle(2);
        @(negedge clk);
        chk("t6_partial_gone", 32'(rq.size()), 32'd0);
        burst(1, 5'd7, 12'h5A5);
        idle(2);
        @(negedge clk);
        chk("t6_full_count", 32'(rq.size()), 32'd1);
        chk("t6_full_ch7", 32'(rq[0]), 32'({5'd7, 12'h5A5}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
